// File: rtl/student_or8way.sv
// 8-input OR reduction with registered companions: delayed OR, popcount,
// lowest set index, a sticky "seen a one" flag and a rising-edge pulse.
module student_or8way (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic       clr,
  output logic       out,
  output logic       out_q,
  output logic       sticky,
  output logic [2:0] first_idx,
  output logic [3:0] count,
  output logic       rise
);

  logic       out_q_prev_r;
  logic [3:0] count_s;
  logic [2:0] first_idx_s;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'b000, v[i]};
    end
    return acc;
  endfunction

  // Scan from the top down so the last hit is the lowest set bit; all-zero gives 0.
  function automatic logic [2:0] lowest_idx8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = v[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

  // Combinational reduction plus the per-word statistics fed to the registers.
  always_comb begin
    out         = |in;
    count_s     = popcount8(in);
    first_idx_s = lowest_idx8(in);
  end

  // Registered outputs; set of sticky takes priority over clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= 1'b0;
      out_q_prev_r <= 1'b0;
      sticky       <= 1'b0;
      first_idx    <= 3'd0;
      count        <= 4'd0;
      rise         <= 1'b0;
    end else begin
      out_q        <= out;
      out_q_prev_r <= out_q;
      rise         <= out_q & ~out_q_prev_r;
      first_idx    <= first_idx_s;
      count        <= count_s;
      if (out) begin
        sticky <= 1'b1;
      end else if (clr) begin
        sticky <= 1'b0;
      end else begin
        sticky <= sticky;
      end
    end
  end

endmodule

// File: tb/tb_student_or8way.sv
// Self-checking bench for student_or8way: combinational sweep, vector table,
// hand-written sticky/rise/reset sequences and randomized traffic vs a model.
module tb_student_or8way;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       clr;
  logic       out;
  logic       out_q;
  logic       sticky;
  logic [2:0] first_idx;
  logic [3:0] count;
  logic       rise;

  int passed = 0;
  int total  = 0;

  student_or8way dut (
    .clk(clk), .rst_n(rst_n), .in(in), .clr(clr), .out(out), .out_q(out_q),
    .sticky(sticky), .first_idx(first_idx), .count(count), .rise(rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (values visible after the most recent edge).
  logic m_out_q, m_sticky, m_rise;
  int   m_count, m_first;
  logic oq_hist[$];   // out_q values over time, newest last

  function automatic int ref_popcount(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int ref_lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, sample #1 later.
  task automatic apply(input logic [7:0] v, input logic c, input logic r);
    logic any;
    in = v; clr = c; rst_n = r;
    any = (v != 8'd0);
    @(posedge clk);
    if (!r) begin
      m_out_q = 1'b0; m_sticky = 1'b0; m_rise = 1'b0; m_count = 0; m_first = 0;
      oq_hist = '{1'b0, 1'b0};
    end else begin
      m_rise   = oq_hist[$] && !oq_hist[$-1];
      m_out_q  = any;
      m_count  = ref_popcount(v);
      m_first  = ref_lowest(v);
      m_sticky = any ? 1'b1 : (c ? 1'b0 : m_sticky);
      oq_hist.push_back(any);
      if (oq_hist.size() > 4) void'(oq_hist.pop_front());
    end
    #1;
  endtask

  typedef struct {
    logic [7:0] v;
    logic       c;
    logic       r;
    logic       e_out;
    logic       e_oq;
    int         e_cnt;
    int         e_fi;
    logic       e_st;
    logic       e_rise;
  } vec_t;

  typedef struct {
    logic [7:0] v;
    logic       e_out;
  } comb_t;

  initial begin
    comb_t cv[5];
    vec_t  tv[11];

    cv[0] = '{8'b00000000, 1'b0};
    cv[1] = '{8'b11111111, 1'b1};
    cv[2] = '{8'b00010000, 1'b1};
    cv[3] = '{8'b00000001, 1'b1};
    cv[4] = '{8'b00100110, 1'b1};

    //            in           clr   rst   out   oq   cnt fi  st    rise
    tv[0]  = '{8'b00100110, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1, 1'b1, 1'b0};
    tv[1]  = '{8'b11111111, 1'b0, 1'b1, 1'b1, 1'b1, 8, 0, 1'b1, 1'b1};
    tv[2]  = '{8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tv[3]  = '{8'b00010000, 1'b1, 1'b1, 1'b1, 1'b1, 1, 4, 1'b1, 1'b0};
    tv[4]  = '{8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1};
    tv[5]  = '{8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[6]  = '{8'b00000001, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0};
    tv[7]  = '{8'b10000000, 1'b0, 1'b1, 1'b1, 1'b1, 1, 7, 1'b1, 1'b1};
    tv[8]  = '{8'b10000000, 1'b0, 1'b1, 1'b1, 1'b1, 1, 7, 1'b1, 1'b0};
    tv[9]  = '{8'b11111111, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tv[10] = '{8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};

    in = 8'd0; clr = 1'b0; rst_n = 1'b0;
    oq_hist = '{1'b0, 1'b0};

    // Combinational sweep, no clock edge waited on.
    for (int i = 0; i < 5; i++) begin
      in = cv[i].v;
      #1;
      check("comb_out", out, cv[i].e_out);
    end

    // Reset state.
    apply(8'b11111111, 1'b1, 1'b0);
    check("rst_out_q", out_q, 0);
    check("rst_count", count, 0);
    check("rst_first_idx", first_idx, 0);
    check("rst_sticky", sticky, 0);
    check("rst_rise", rise, 0);
    check("rst_out_tracks", out, 1);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      apply(tv[i].v, tv[i].c, tv[i].r);
      check($sformatf("tv%0d_out", i), out, tv[i].e_out);
      check($sformatf("tv%0d_out_q", i), out_q, tv[i].e_oq);
      check($sformatf("tv%0d_count", i), count, tv[i].e_cnt);
      check($sformatf("tv%0d_first_idx", i), first_idx, tv[i].e_fi);
      check($sformatf("tv%0d_sticky", i), sticky, tv[i].e_st);
      check($sformatf("tv%0d_rise", i), rise, tv[i].e_rise);
    end

    // Sticky sequence.
    apply(8'd0, 1'b0, 1'b0);
    apply(8'b00010000, 1'b0, 1'b1);
    check("sticky_set", sticky, 1);
    apply(8'd0, 1'b0, 1'b1);
    check("sticky_hold", sticky, 1);
    apply(8'd0, 1'b1, 1'b1);
    check("sticky_clr", sticky, 0);
    apply(8'b00000001, 1'b1, 1'b1);
    check("sticky_set_wins", sticky, 1);

    // Rise sequence: single pulse one cycle after out_q first goes high.
    apply(8'd0, 1'b0, 1'b0);
    apply(8'd0, 1'b0, 1'b1);
    check("rise_idle", rise, 0);
    apply(8'b00000001, 1'b0, 1'b1);
    check("rise_oq_up", out_q, 1);
    check("rise_c1", rise, 0);
    apply(8'b00000001, 1'b0, 1'b1);
    check("rise_c2", rise, 1);
    apply(8'b00000001, 1'b0, 1'b1);
    check("rise_c3", rise, 0);

    // Reset mid-operation.
    apply(8'b11111111, 1'b0, 1'b1);
    apply(8'b11111111, 1'b0, 1'b0);
    check("midrst_out_q", out_q, 0);
    check("midrst_count", count, 0);
    check("midrst_first_idx", first_idx, 0);
    check("midrst_sticky", sticky, 0);
    check("midrst_rise", rise, 0);
    check("midrst_out", out, 1);

    // Randomized traffic against the model; sparse words make out toggle.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = 8'(1 << $urandom_range(0, 7));
      apply(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) != 0));
      check("rnd_out", out, (v != 8'd0));
      check("rnd_out_q", out_q, m_out_q);
      check("rnd_count", count, m_count);
      check("rnd_first_idx", first_idx, m_first);
      check("rnd_sticky", sticky, m_sticky);
      check("rnd_rise", rise, m_rise);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
